// File: rtl/rb_dump_if.sv
// Output word stream of the register-bank dumper: a valid/ready handshake
// carrying one register value and its index per accepted transfer.
interface rb_dump_if;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic [4:0]  outAddr;

    // Producer side (the dumper)
    modport master (
        output outValid,
        output outData,
        output outAddr,
        input  outReady
    );

    // Consumer side (downstream sink)
    modport slave (
        input  outValid,
        input  outData,
        input  outAddr,
        output outReady
    );
endinterface

// File: rtl/rb_dump.sv
// Register-bank dumper: walks an inclusive, wrap-around register range
// through the bank's combinational read port and streams each
// (index, value) pair out over a valid/ready handshake, one word every
// two cycles at best. Read-only towards the bank.
module rb_dump (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [4:0]  firstReg,
    input  logic [4:0]  lastReg,
    output logic [4:0]  rbReadReg,
    input  logic [31:0] rbReadData,
    output logic        busy,
    output logic        done,
    rb_dump_if.master   outPort
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        HOLD   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [4:0]  ptr;
    logic [4:0]  endReg;
    logic        validReg;
    logic [31:0] dataReg;
    logic [4:0]  addrReg;

    logic        loadRange;
    logic        capture;
    logic        advance;
    logic        dropValid;
    logic        handshake;

    assign handshake = validReg && outPort.outReady;

    // Next-state and control strobes; abort outranks any handshake
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        stateNext = state;
        loadRange = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        dropValid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    loadRange = 1'b1;
                    stateNext = READ;
                end
            end
            READ: begin
                if (abort) begin
                    stateNext = IDLE;
                end else begin
                    capture   = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    dropValid = 1'b1;
                    stateNext = IDLE;
                end else if (handshake) begin
                    dropValid = 1'b1;
                    if (ptr == endReg) begin
                        stateNext = FINISH;
                    end else begin
                        advance   = 1'b1;
                        stateNext = READ;
                    end
                end
            end
            FINISH: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Range pointer and output word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= 5'd0;
            endReg   <= 5'd0;
            validReg <= 1'b0;
            dataReg  <= 32'd0;
            addrReg  <= 5'd0;
        end else begin
            if (loadRange) begin
                ptr    <= firstReg;
                endReg <= lastReg;
            end else if (advance) begin
                ptr <= ptr + 5'd1;  // 5-bit add wraps 31 -> 0
            end
            if (capture) begin
                dataReg  <= rbReadData;
                addrReg  <= ptr;
                validReg <= 1'b1;
            end else if (dropValid) begin
                validReg <= 1'b0;
            end
        end
    end

    assign rbReadReg        = ptr;
    assign busy             = (state != IDLE);
    assign done             = (state == FINISH) && !abort;
    assign outPort.outValid = validReg;
    assign outPort.outData  = dataReg;
    assign outPort.outAddr  = addrReg;
endmodule

// File: tb/tb_rb_dump.sv
// Self-checking bench for rb_dump: a bank model feeds the read port, a
// table of dump ranges plus random ranges are checked against an expected
// word list computed from the range arithmetic, and abort/reset corner
// cases are exercised by hand.
module tb_rb_dump;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [4:0]  firstReg;
    logic [4:0]  lastReg;
    logic [4:0]  rbReadReg;
    logic [31:0] rbReadData;
    logic        busy;
    logic        done;

    rb_dump_if outIf ();

    logic [31:0] bank [32];
    assign rbReadData = bank[rbReadReg];

    rb_dump dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .firstReg   (firstReg),
        .lastReg    (lastReg),
        .rbReadReg  (rbReadReg),
        .rbReadData (rbReadData),
        .busy       (busy),
        .done       (done),
        .outPort    (outIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         count;
        int         readyPct;
        int         stallWord;
        int         stallLen;
        bit         startBusy;
    } vec_t;

    word_t expQ[$];

    task automatic preloadTimes3();
        for (int n = 0; n < 32; n++) bank[n] = 32'(n * 3);
    endtask

    // Run one full dump from IDLE and check every word, latency, stalls and done.
    task automatic runDump(input string tag, input logic [4:0] f, input logic [4:0] l,
                           input int expCount, input int readyPct,
                           input int stallWord, input int stallLen, input bit startBusy);
        int          cyc;
        int          wordIdx;
        int          stallLeft;
        int          firstSeen;
        bit          holdPrev;
        bit          finished;
        logic [31:0] prevData;
        logic [4:0]  prevAddr;
        word_t       w;
        int          budget;
        expQ.delete();
        for (int i = 0; i < expCount; i++) begin
            w.addr = 5'((int'(f) + i) % 32);
            w.data = bank[w.addr];
            expQ.push_back(w);
        end
        budget    = 100 + expCount * 40;
        wordIdx   = 0;
        stallLeft = stallLen;
        firstSeen = -1;
        holdPrev  = 1'b0;
        finished  = 1'b0;
        prevData  = '0;
        prevAddr  = '0;
        start     = 1'b1;
        firstReg  = f;
        lastReg   = l;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        while (cyc < budget) begin
            start = (startBusy && cyc == 3);
            if (startBusy && cyc == 3) begin
                firstReg = 5'd20;
                lastReg  = 5'd25;
            end
            if (holdPrev) begin
                check({tag, "_stall_valid"}, 32'(outIf.outValid), 32'd1);
                check({tag, "_stall_data"}, outIf.outData, prevData);
                check({tag, "_stall_addr"}, 32'(outIf.outAddr), 32'(prevAddr));
            end
            if (done) begin
                check({tag, "_done_words_left"}, 32'(expQ.size()), 32'd0);
                check({tag, "_done_valid"}, 32'(outIf.outValid), 32'd0);
                finished = 1'b1;
                break;
            end
            if (outIf.outValid) begin
                if (firstSeen < 0) begin
                    firstSeen = cyc;
                    check({tag, "_latency"}, 32'(firstSeen), 32'd2);
                end
                if (wordIdx == stallWord && stallLeft > 0) begin
                    outIf.outReady = 1'b0;
                    stallLeft--;
                end else begin
                    outIf.outReady = ($urandom_range(99) < readyPct);
                end
                if (outIf.outReady) begin
                    if (expQ.size() == 0) begin
                        check({tag, "_extra_word"}, 32'(wordIdx), 32'(expCount));
                    end else begin
                        w = expQ.pop_front();
                        check($sformatf("%s_w%0d_addr", tag, wordIdx), 32'(outIf.outAddr), 32'(w.addr));
                        check($sformatf("%s_w%0d_data", tag, wordIdx), outIf.outData, w.data);
                    end
                    wordIdx++;
                    holdPrev = 1'b0;
                end else begin
                    holdPrev = 1'b1;
                    prevData = outIf.outData;
                    prevAddr = outIf.outAddr;
                end
            end else begin
                holdPrev       = 1'b0;
                outIf.outReady = $urandom_range(1);
            end
            @(negedge clk);
            cyc++;
        end
        start          = 1'b0;
        outIf.outReady = 1'b0;
        check({tag, "_finished_in_budget"}, 32'(finished), 32'd1);
        check({tag, "_word_count"}, 32'(wordIdx), 32'(expCount));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    vec_t vecs[8];
    int   doneSeen;
    bit   found;

    initial begin
        logic [4:0] rf;
        logic [4:0] rl;
        int         rc;

        rst_n          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        firstReg       = 5'd0;
        lastReg        = 5'd0;
        outIf.outReady = 1'b0;
        preloadTimes3();

        // Reset state while rst_n is low, before any clock edge
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(outIf.outValid), 32'd0);
        check("rst_data", outIf.outData, 32'd0);
        check("rst_addr", 32'(outIf.outAddr), 32'd0);
        check("rst_readreg", 32'(rbReadReg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table of ranges with hand-computed word counts
        vecs[0] = '{5'd4,  5'd7,  4,  100, -1, 0, 1'b0};
        vecs[1] = '{5'd30, 5'd1,  4,  100, -1, 0, 1'b0};
        vecs[2] = '{5'd4,  5'd7,  4,  100,  1, 5, 1'b0};
        vecs[3] = '{5'd9,  5'd9,  1,  100, -1, 0, 1'b0};
        vecs[4] = '{5'd0,  5'd31, 32, 70,  -1, 0, 1'b0};
        vecs[5] = '{5'd31, 5'd0,  2,  100, -1, 0, 1'b0};
        vecs[6] = '{5'd10, 5'd15, 6,  100, -1, 0, 1'b1};
        vecs[7] = '{5'd5,  5'd4,  32, 60,  -1, 0, 1'b0};
        for (int v = 0; v < 8; v++) begin
            runDump($sformatf("vec%0d", v), vecs[v].first, vecs[v].last, vecs[v].count,
                    vecs[v].readyPct, vecs[v].stallWord, vecs[v].stallLen, vecs[v].startBusy);
            @(negedge clk);
        end

        // Abort coinciding with the handshake of word 2 of 4
        outIf.outReady = 1'b1;
        start    = 1'b1;
        firstReg = 5'd4;
        lastReg  = 5'd7;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (outIf.outValid && outIf.outAddr == 5'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("abort_reach_word2", 32'(found), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(outIf.outValid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        doneSeen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) doneSeen++;
            @(negedge clk);
        end
        outIf.outReady = 1'b0;
        check("abort_no_done", 32'(doneSeen), 32'd0);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Asynchronous reset between edges while in READ
        start    = 1'b1;
        firstReg = 5'd4;
        lastReg  = 5'd7;
        @(negedge clk);
        start = 1'b0;
        check("arst_in_read", 32'({busy, outIf.outValid}), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_valid", 32'(outIf.outValid), 32'd0);
        check("arst_data", outIf.outData, 32'd0);
        check("arst_addr", 32'(outIf.outAddr), 32'd0);
        check("arst_readreg", 32'(rbReadReg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_idle_after", 32'(busy), 32'd0);
        runDump("post_rst", 5'd9, 5'd9, 1, 100, -1, 0, 1'b0);
        @(negedge clk);

        // Random bank contents and ranges against the range-arithmetic model
        for (int n = 0; n < 32; n++) bank[n] = $urandom;
        for (int t = 0; t < 6; t++) begin
            rf = 5'($urandom_range(31));
            rl = 5'($urandom_range(31));
            rc = ((int'(rl) - int'(rf)) % 32 + 32) % 32 + 1;
            runDump($sformatf("rnd%0d", t), rf, rl, rc, 50, -1, 0, 1'b0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
